pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed MEM/WB-style pipeline register.
- Carries a DATA_W-bit stage bundle (ALU result, read data, rd address, control bits, packed by the instantiating stage) between two pipeline stages.
- Uses a valid/ready handshake, a 2-entry skid buffer so in_ready_o is fully registered, a synchronous flush for branch/exception squash, and a saturating backpressure counter for performance debug.
- Sits between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 32, width of the stage bundle in bits (must be ≥1).
- CNT_W, 16, width of the stall counter in bits (must be ≥1).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- flush_i  input  1  synchronous squash of all held beats.
- in_valid_i  input  1  upstream beat valid.
- in_ready_o  output  1  block can accept a beat; registered.
- in_data_i  input  DATA_W  upstream bundle.
- out_valid_o  output  1  downstream beat valid.
- out_ready_i  input  1  downstream accepts.
- out_data_o  output  DATA_W  downstream bundle; driven directly from the main register.
- count_o  output  2  occupancy, range 0..2.
- stat_clr_i  input  1  synchronous clear of the stall counter.
- stall_cnt_o  output  CNT_W  count of cycles with out_valid_o=1 and out_ready_i=0.

Behaviour:
- Handshake events:
  - accept = in_valid_i & in_ready_o.
  - fire = out_valid_o & out_ready_i.
  - Upstream must hold in_data_i stable while in_valid_i=1 and in_ready_o=0.
- Storage: main register M and skid register S, each DATA_W bits.
- State encoding: EMPTY=0, ONE=1, FULL=2; count_o equals the state.
- Derived outputs:
  - out_valid_o = (state != EMPTY).
  - in_ready_o = (state != FULL).
  - Both are functions of state only; no combinational in→out paths.
- Transitions (flush_i=0):
  - EMPTY: accept → ONE, M<=in_data_i.
  - ONE, accept & fire → ONE, M<=in_data_i.
  - ONE, accept only → FULL, S<=in_data_i.
  - ONE, fire only → EMPTY.
  - ONE, neither → ONE.
  - FULL: accept is impossible. fire → ONE, M<=S. No fire → hold.
- Latency and throughput:
  - A beat accepted at edge N is presented with out_valid_o=1 after edge N.
  - Sustained throughput is 1 beat/cycle when out_ready_i=1.
- Ordering: strict FIFO; S is always younger than M.
- Flush:
  - flush_i=1 has highest priority: next state EMPTY.
  - Any beat accepted in the flush cycle is discarded.
  - A fire in the same cycle still completes downstream; the beat counts as delivered.
  - M and S contents are unchanged; only state is cleared.
- out_data_o when out_valid_o=0: holds the last M value (0 after reset). Benches must not check it.
- Stall counter:
  - Increments by 1 each cycle with out_valid_o & !out_ready_i.
  - Saturates at 2^CNT_W-1; never wraps.
  - stat_clr_i=1 sets it to 0, with priority over increment.
  - Flush does not affect it.
- Reset (asynchronous, any time including mid-transfer):
  - state=EMPTY, M=0, S=0, stall_cnt_o=0.
  - out_valid_o=0, in_ready_o=1, count_o=0.
  - Held beats are lost.
- Simultaneous flush_i & stat_clr_i: both take effect.

Test Plan:
- Reset: deassert rst_i after 3 cycles → out_valid_o=0, in_ready_o=1, count_o=0, out_data_o=0, stall_cnt_o=0.
- Single beat: drive 0xDEADBEEF with in_valid_i=1 for 1 cycle, out_ready_i=1 → out_valid_o=1 with 0xDEADBEEF exactly 1 cycle later, then out_valid_o=0.
- Streaming: 100 consecutive beats 0..99, out_ready_i=1 always → in_ready_o stays 1, outputs 0..99 in order, one per cycle, count_o never exceeds 1.
- Backpressure:
  - Hold out_ready_i=0 and offer beats A, B, C → A and B accepted, count_o=2, in_ready_o=0, C held upstream.
  - Release out_ready_i → output order A, B, C, no loss or duplication.
  - stall_cnt_o equals the number of blocked cycles.
- Flush: with FULL (A, B) and in_valid_i=1, pulse flush_i → next cycle count_o=0, out_valid_o=0; A, B and the offered beat never appear downstream.
- Saturation and reset: with CNT_W=2, hold backpressure for 6 cycles → stall_cnt_o=3. Pulse stat_clr_i → 0. Assert rst_i asynchronously mid-stream → outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline register between two CPU stages.
//
// Carries a DATA_W-bit stage bundle with a valid/ready handshake. A 2-entry
// skid buffer (main register M, skid register S) keeps in_ready_o a pure
// function of registered state, which breaks the ready path between stages.
// flush_i squashes every held beat in one cycle. A saturating stall counter
// counts the cycles where a beat is offered downstream but not taken.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-low
//   flush_i      synchronous squash of all held beats
//   in_valid_i   upstream beat valid
//   in_ready_o   block can accept a beat (registered)
//   in_data_i    upstream bundle
//   out_valid_o  downstream beat valid
//   out_ready_i  downstream accepts
//   out_data_o   downstream bundle, driven straight from M
//   count_o      occupancy 0..2
//   stat_clr_i   synchronous clear of the stall counter
//   stall_cnt_o  cycles with out_valid_o=1 and out_ready_i=0 (saturating)
//
// state | meaning
// ------+------------------------------------------------
// EMPTY | nothing held; M shows the last beat (stale)
// ONE   | M holds the oldest beat, presented downstream
// FULL  | M holds the oldest beat, S the younger one

module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o,
  input  logic              stat_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept;
  logic              fire;

  // Handshake outputs depend on state only, so there is no in->out path.
  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = (state_q != FULL);
  assign out_data_o  = m_q;
  assign count_o     = state_q;
  assign stall_cnt_o = stall_q;

  assign accept = in_valid_i & in_ready_o;
  assign fire   = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    if (flush_i) begin
      // Squash: drop all held beats and any beat accepted this cycle.
      // Data registers are left alone; only occupancy is cleared.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_data_i;
          end
        end
        ONE: begin
          if (accept && fire) begin
            m_d = in_data_i;
          end else if (accept) begin
            state_d = FULL;
            s_d     = in_data_i;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready_o is low here, so only a downstream fire can move us.
          if (fire) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (stat_clr_i) begin
      stall_d = '0;
    end else if (out_valid_o && !out_ready_i && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        out_ready_i = 1'b0;
  logic        stat_clr_i = 1'b0;

  logic        in_ready_o, out_valid_o;
  logic [31:0] out_data_o;
  logic [1:0]  count_o;
  logic [15:0] stall_cnt_o;

  // Second instance with a 2-bit stall counter, driven by the same inputs,
  // to exercise saturation.
  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_out_data;
  logic [1:0]  sat_count;
  logic [1:0]  sat_stall;

  int n_pass = 0;
  int n_total = 0;

  pipe_stage_skid #(.DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .count_o(count_o), .stat_clr_i(stat_clr_i), .stall_cnt_o(stall_cnt_o)
  );

  pipe_stage_skid #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(sat_in_ready), .in_data_i(in_data_i),
    .out_valid_o(sat_out_valid), .out_ready_i(out_ready_i), .out_data_o(sat_out_data),
    .count_o(sat_count), .stat_clr_i(stat_clr_i), .stall_cnt_o(sat_stall)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of at most two beats plus an unbounded count of
  // blocked cycles since the last clear (saturation applied at compare time).
  logic [31:0] mq[$];
  int          mcnt = 0;
  bit          acc_last = 0;
  bit          m_v, m_r, m_acc, m_fire;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mq.delete();
      mcnt = 0;
      acc_last = 0;
    end else begin
      m_v    = (mq.size() != 0);
      m_r    = (mq.size() < 2);
      m_acc  = in_valid_i && m_r;
      m_fire = m_v && out_ready_i;
      if (stat_clr_i) mcnt = 0;
      else if (m_v && !out_ready_i) mcnt++;
      if (m_fire) void'(mq.pop_front());
      if (flush_i) mq.delete();
      else if (m_acc) mq.push_back(in_data_i);
      acc_last = m_acc;
    end
  end

  always @(negedge clk_i) begin
    chk("cmp_out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
    chk("cmp_in_ready",  64'(in_ready_o),  64'(mq.size() < 2));
    chk("cmp_count",     64'(count_o),     64'(mq.size()));
    if (mq.size() != 0) chk("cmp_out_data", 64'(out_data_o), 64'(mq[0]));
    chk("cmp_stall",     64'(stall_cnt_o), 64'((mcnt > 65535) ? 65535 : mcnt));
    chk("cmp_stall_sat", 64'(sat_stall),   64'((mcnt > 3) ? 3 : mcnt));
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_in_ready",  64'(in_ready_o),  64'd1);
    chk("rst_count",     64'(count_o),     64'd0);
    chk("rst_out_data",  64'(out_data_o),  64'd0);
    chk("rst_stall",     64'(stall_cnt_o), 64'd0);

    // Single beat
    in_valid_i = 1'b1; in_data_i = 32'hDEADBEEF; out_ready_i = 1'b1;
    tick;
    in_valid_i = 1'b0;
    chk("single_valid", 64'(out_valid_o), 64'd1);
    chk("single_data",  64'(out_data_o),  64'hDEADBEEF);
    tick;
    chk("single_gone",  64'(out_valid_o), 64'd0);

    // Streaming 0..99 at full rate
    for (int i = 0; i < 100; i++) begin
      in_valid_i = 1'b1; in_data_i = 32'(i);
      tick;
      chk("stream_data",  64'(out_data_o), 64'(i));
      chk("stream_ready", 64'(in_ready_o), 64'd1);
      chk("stream_count", 64'(count_o),    64'd1);
    end
    in_valid_i = 1'b0;
    tick;

    // Backpressure: A, B accepted, C held upstream
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 32'hA;
    tick;
    chk("bp_count1", 64'(count_o), 64'd1);
    in_data_i = 32'hB;
    tick;
    chk("bp_count2", 64'(count_o), 64'd2);
    chk("bp_ready0", 64'(in_ready_o), 64'd0);
    in_data_i = 32'hC;
    repeat (3) tick;
    chk("bp_hold_count", 64'(count_o), 64'd2);
    chk("bp_head_A",     64'(out_data_o), 64'hA);
    chk("bp_stall",      64'(stall_cnt_o), 64'd4);
    chk("bp_stall_sat",  64'(sat_stall), 64'd3);
    out_ready_i = 1'b1;
    tick;
    chk("bp_out_B", 64'(out_data_o), 64'hB);
    tick;
    in_valid_i = 1'b0;
    chk("bp_out_C", 64'(out_data_o), 64'hC);
    tick;
    chk("bp_drained", 64'(out_valid_o), 64'd0);
    chk("bp_stall_kept", 64'(stall_cnt_o), 64'd4);

    // Clear stats
    stat_clr_i = 1'b1;
    tick;
    stat_clr_i = 1'b0;
    chk("clr_stall",     64'(stall_cnt_o), 64'd0);
    chk("clr_stall_sat", 64'(sat_stall), 64'd0);

    // Fill with A, B, block 6 cycles, then flush with C offered
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 32'h1A;
    tick;
    in_data_i = 32'h1B;
    tick;
    in_data_i = 32'h1C;
    repeat (5) tick;
    chk("sat_stall_main", 64'(stall_cnt_o), 64'd6);
    chk("sat_stall_2b",   64'(sat_stall), 64'd3);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    chk("flush_stall", 64'(stall_cnt_o), 64'd7);
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("flush_nothing_out", 64'(out_valid_o), 64'd0);
    end

    // Flush and stat clear together
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h55;
    tick;
    in_valid_i = 1'b0;
    tick;
    flush_i = 1'b1; stat_clr_i = 1'b1;
    tick;
    flush_i = 1'b0; stat_clr_i = 1'b0;
    chk("both_count", 64'(count_o), 64'd0);
    chk("both_stall", 64'(stall_cnt_o), 64'd0);

    // Randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 2000; i++) begin
      if (!(in_valid_i && !acc_last)) begin
        in_valid_i = ($urandom_range(0, 99) < 70);
        in_data_i  = $urandom;
      end
      out_ready_i = ($urandom_range(0, 99) < 60);
      flush_i     = ($urandom_range(0, 19) == 0);
      stat_clr_i  = ($urandom_range(0, 29) == 0);
      tick;
    end

    // Async reset mid-stream, away from any clock edge
    flush_i = 1'b0; stat_clr_i = 1'b0;
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h77;
    tick;
    tick;
    #2 rst_i = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_in_ready",  64'(in_ready_o),  64'd1);
    chk("arst_count",     64'(count_o),     64'd0);
    chk("arst_out_data",  64'(out_data_o),  64'd0);
    chk("arst_stall",     64'(stall_cnt_o), 64'd0);
    in_valid_i = 1'b0;
    repeat (2) tick;
    rst_i = 1'b1;
    repeat (3) tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
